ram_dp_be_pipe: RTL
===================

// Module: ram_dp_be_pipe
// PURPOSE
//  True dual-port, byte-enabled synchronous RAM for AXI slave memory back-ends.
//  - Byte count is generic. Read latency is configurable. Read-during-write mode is selectable.
//  - Per-port enable, with a read-data-valid strobe.
//  - Deterministic same-address collision resolution between ports, plus a collision flag.
//  - Sits behind the AXI slave read/write engines; one port per engine.
// PARAMETERS
//  ADDR_WIDTH    16  word address width; depth = 2**ADDR_WIDTH words
//  BATCH_WIDTH    4  bytes per word (>=1); one byte enable per byte
//  BYTE_WIDTH     8  bits per byte
//  READ_LATENCY   1  cycles from accepted access to data_x/rvalid_x; legal 1..4
//  RDW_MODE       0  same-port read-during-write: 0=write-first (merged new word), 1=read-first (old word)
// PORTS
//  clk_i       in   1                     clock, all logic on posedge
//  rst_ni      in   1                     async active-low reset
//  en_a        in   1                     port A access strobe (read, or write if write_en_a)
//  addr_a      in   ADDR_WIDTH            port A word address
//  write_a     in   BYTE_WIDTH*BATCH_WIDTH port A write data
//  byte_en_a   in   BATCH_WIDTH           port A byte enables
//  write_en_a  in   1                     port A write (qualified by en_a)
//  data_a      out  BYTE_WIDTH*BATCH_WIDTH port A read data
//  rvalid_a    out  1                     port A data_a valid
//  en_b/addr_b/write_b/byte_en_b/write_en_b/data_b/rvalid_b: identical set for port B
//  collision_o out  1                     same-address conflict, registered, 1 cycle after the access
// BEHAVIOUR
//  - Reset (rst_ni low, async):
//    - data_a, data_b, rvalid_a, rvalid_b, collision_o and all read-pipeline stages -> 0.
//    - Array contents are not reset.
//    - No array write occurs on an edge where rst_ni is low.
//    - Reset mid-access flushes in-flight reads: no rvalid for them after release.
//  - Access: accepted on posedge when en_x=1.
//    - en_x=0: no array write.
//    - en_x=0: a 0 enters the pipeline stage for rvalid_x, and data_x holds its last value.
//    - Every accepted access (read or write) produces exactly one rvalid_x pulse, READ_LATENCY cycles later.
//  - Write: en_x & write_en_x.
//    - Byte i is updated iff byte_en_x[i]. Bytes with byte_en_x[i]=0 keep their old value.
//    - byte_en_x=0 is legal: no change, returns the read word.
//  - Returned word on a same-port write:
//    - RDW_MODE=0: merged word (new enabled bytes, old disabled bytes).
//    - RDW_MODE=1: pre-write word.
//  - Latency:
//    - Stage 1 is the array read register.
//    - Stages 2..READ_LATENCY are plain registers, data and rvalid shifted together.
//    - Fully pipelined: a new access every cycle per port.
//  - Cross-port, same addr, same cycle, both en:
//    - Both write: per byte, A wins where byte_en_a[i]; B is applied where only byte_en_b[i].
//    - Both write, returned words: each port returns the final merged word if RDW_MODE=0, else the old word.
//    - One port writes, other reads: the reader always gets the old word (read-first across ports, either mode).
//    - collision_o=1 on the next cycle iff addr_a==addr_b & en_a & en_b & (write_en_a|write_en_b).
//    - Two reads never flag.
//  - Width rules:
//    - Generate-loop over BATCH_WIDTH; no hard-coded byte indices.
//    - Byte i = bits [i*BYTE_WIDTH +: BYTE_WIDTH].
//  - Illegal READ_LATENCY (0 or >4): elaboration-time $error.
// TESTING
//  1. Reset: assert rst_ni=0 mid-burst -> all outputs 0 immediately; release -> no stale rvalid.
//  2. Byte enables: BATCH_WIDTH=4.
//     - Write 0xAABBCCDD to addr 0x10, be=4'b1111.
//     - Then write 0x11223344 to addr 0x10, be=4'b0101.
//     - Read 0x10 -> 0xAA22CC44.
//  3. Latency/throughput: READ_LATENCY=3, back-to-back reads of addr 0..7 on A.
//     - rvalid_a high for cycles 3..10 after the first en_a.
//     - data in address order.
//  4. RDW: addr 0x5 holds 0x00000000. Write 0xFFFFFFFF, be=4'b0011, on A.
//     - RDW_MODE=0: data_a = 0x0000FFFF.
//     - RDW_MODE=1: data_a = 0x00000000.
//  5. Collision: same cycle on addr 0x20 (old value 0x00000000).
//     - A writes 0x11111111 be=4'b1100; B writes 0x22222222 be=4'b0110.
//     - Array becomes 0x11112200; collision_o pulses 1 cycle.
//     - Simultaneous read/write on both ports -> reader gets the old word.
//  6. Random two-port traffic vs scoreboard model, BATCH_WIDTH=2 and 8, BYTE_WIDTH=9 -> zero mismatches.

Source files
------------

// File: rtl/ram_dp_be_pipe.sv
`default_nettype none
// ============================================================================
// Module : ram_dp_be_pipe
// True dual-port byte-enabled RAM with a configurable-latency read pipeline.
// Rev    : 1.0
// ============================================================================
module ram_dp_be_pipe #(
  parameter int ADDR_WIDTH   = 16,
  parameter int BATCH_WIDTH  = 4,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              en_a,
  input  logic [ADDR_WIDTH-1:0]             addr_a,
  input  logic [BYTE_WIDTH*BATCH_WIDTH-1:0] write_a,
  input  logic [BATCH_WIDTH-1:0]            byte_en_a,
  input  logic                              write_en_a,
  output logic [BYTE_WIDTH*BATCH_WIDTH-1:0] data_a,
  output logic                              rvalid_a,
  input  logic                              en_b,
  input  logic [ADDR_WIDTH-1:0]             addr_b,
  input  logic [BYTE_WIDTH*BATCH_WIDTH-1:0] write_b,
  input  logic [BATCH_WIDTH-1:0]            byte_en_b,
  input  logic                              write_en_b,
  output logic [BYTE_WIDTH*BATCH_WIDTH-1:0] data_b,
  output logic                              rvalid_b,
  output logic                              collision_o
);

  localparam int DATA_W = BYTE_WIDTH * BATCH_WIDTH;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_lat_check
    $error("ram_dp_be_pipe: READ_LATENCY must be in 1..4");
  end

  logic              acc_wr_a;
  logic              acc_wr_b;
  logic              same_addr;
  logic              arr_wr_ok;
  logic [DATA_W-1:0] old_a;
  logic [DATA_W-1:0] old_b;
  logic [DATA_W-1:0] merged_a;
  logic [DATA_W-1:0] merged_b;
  logic [DATA_W-1:0] ret_a;
  logic [DATA_W-1:0] ret_b;

  assign acc_wr_a  = en_a & write_en_a;
  assign acc_wr_b  = en_b & write_en_b;
  assign same_addr = (addr_a == addr_b);
  assign arr_wr_ok = rst_ni;

  // One storage array per byte lane; A's write is issued last so it wins a shared address.
  for (genvar i = 0; i < BATCH_WIDTH; i++) begin : g_lane
    logic [BYTE_WIDTH-1:0] lane_mem [DEPTH];
    logic                  lane_we_a;
    logic                  lane_we_b;

    assign lane_we_a = arr_wr_ok & acc_wr_a & byte_en_a[i];
    assign lane_we_b = arr_wr_ok & acc_wr_b & byte_en_b[i];

    always_ff @(posedge clk_i) begin
      if (lane_we_b) lane_mem[addr_b] <= write_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (lane_we_a) lane_mem[addr_a] <= write_a[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    assign old_a[i*BYTE_WIDTH +: BYTE_WIDTH] = lane_mem[addr_a];
    assign old_b[i*BYTE_WIDTH +: BYTE_WIDTH] = lane_mem[addr_b];

    assign merged_a[i*BYTE_WIDTH +: BYTE_WIDTH] =
      (acc_wr_a & byte_en_a[i])             ? write_a[i*BYTE_WIDTH +: BYTE_WIDTH] :
      (acc_wr_b & same_addr & byte_en_b[i]) ? write_b[i*BYTE_WIDTH +: BYTE_WIDTH] :
                                              old_a[i*BYTE_WIDTH +: BYTE_WIDTH];
    assign merged_b[i*BYTE_WIDTH +: BYTE_WIDTH] =
      (acc_wr_a & same_addr & byte_en_a[i]) ? write_a[i*BYTE_WIDTH +: BYTE_WIDTH] :
      (acc_wr_b & byte_en_b[i])             ? write_b[i*BYTE_WIDTH +: BYTE_WIDTH] :
                                              old_b[i*BYTE_WIDTH +: BYTE_WIDTH];
  end

  // Readers always see the pre-write word; only a port's own write can return the merged word.
  assign ret_a = (acc_wr_a && (RDW_MODE == 0)) ? merged_a : old_a;
  assign ret_b = (acc_wr_b && (RDW_MODE == 0)) ? merged_b : old_b;

  logic [READ_LATENCY-1:0][DATA_W-1:0] a_data_q, a_data_d;
  logic [READ_LATENCY-1:0][DATA_W-1:0] b_data_q, b_data_d;
  logic [READ_LATENCY-1:0]             a_vld_q, a_vld_d;
  logic [READ_LATENCY-1:0]             b_vld_q, b_vld_d;
  logic                                collision_q, collision_d;

  always_comb begin
    a_data_d    = a_data_q;
    b_data_d    = b_data_q;
    a_vld_d     = '0;
    b_vld_d     = '0;
    a_data_d[0] = en_a ? ret_a : a_data_q[0];
    b_data_d[0] = en_b ? ret_b : b_data_q[0];
    a_vld_d[0]  = en_a;
    b_vld_d[0]  = en_b;
    for (int j = 1; j < READ_LATENCY; j++) begin
      a_data_d[j] = a_data_q[j-1];
      b_data_d[j] = b_data_q[j-1];
      a_vld_d[j]  = a_vld_q[j-1];
      b_vld_d[j]  = b_vld_q[j-1];
    end
    collision_d = en_a & en_b & same_addr & (write_en_a | write_en_b);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_data_q    <= '0;
      b_data_q    <= '0;
      a_vld_q     <= '0;
      b_vld_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      a_data_q    <= a_data_d;
      b_data_q    <= b_data_d;
      a_vld_q     <= a_vld_d;
      b_vld_q     <= b_vld_d;
      collision_q <= collision_d;
    end
  end

  assign data_a      = a_data_q[READ_LATENCY-1];
  assign data_b      = b_data_q[READ_LATENCY-1];
  assign rvalid_a    = a_vld_q[READ_LATENCY-1];
  assign rvalid_b    = b_vld_q[READ_LATENCY-1];
  assign collision_o = collision_q;

endmodule
`default_nettype wire
